tim_pwm_capture: RTL
====================

Name: tim_pwm_capture

Overview:
- Input-capture timer channel; the receiving end of the timer PWM/compare output.
- Measures period and high time of an external pulse train on `ic_pin`, in prescaled clock ticks.
- Sits beside the timer peripherals on the same `ld_reg`/`data_reg` write bus.
- Raises a capture interrupt flag when each full period completes.

Parameters:
- FILT_LEN, 4, consecutive identical samples required by the input filter (2..15); used only with IC_FILTER_EN.
- CNT_W, 16, width of the prescaler, counter and capture registers.

Ports:
- clk  in  1  system clock
- rst  in  1  reset
- ld_ic_reg  in  4  register select: 0 CR, 1 PSC, 2 SR; any other value = no write
- data_reg  in  32  write data
- ccif_rst  in  1  clears ic_ccif and ic_ocf
- ovf_rst  in  1  clears ic_ovf
- ic_pin  in  1  external asynchronous input
- ic_period  out  CNT_W  last captured period
- ic_high  out  CNT_W  last captured active time
- ic_ccif  out  1  capture-complete flag
- ic_ocf  out  1  overcapture flag
- ic_ovf  out  1  counter-saturation flag
- ic_irq  out  1  interrupt request
- ic_busy  out  1  measurement in progress

Behaviour:
- Reset: rst is asynchronous, active-high. It clears all registers, flags and outputs to 0 and puts the FSM in IDLE.
- CR write: data[0] CEN, data[1] POL (1 = falling edge active), data[2] CCIE, data[3] OVIE.
  - Any CR write forces the FSM to IDLE and clears the prescaler and counter.
  - Captured values are held.
- PSC write: data[CNT_W-1:0]. Takes effect at the next active edge.
- SR write: data[0]=1 clears ccif/ocf; data[1]=1 clears ovf.
- Input path: 2-flop synchronizer, then XOR with POL, then a registered previous sample for edge detect.
  - Active edge = 0→1 of the polarity-corrected signal; inactive edge = 1→0.
- Counter and prescaler advance every clk while CEN=1 and FSM≠IDLE.
  - If psc_cnt==PSC: psc_cnt<=0, cnt<=cnt+1. Otherwise psc_cnt<=psc_cnt+1.
- On an active edge:
  - If PSC==0: cnt<=1, psc_cnt<=0.
  - Otherwise: cnt<=0, psc_cnt<=1.
  - Result: captured value = floor(clocks elapsed / (PSC+1)).
- FSM, with CEN=0 holding it in IDLE:
  - IDLE: active edge → HIGH. No capture.
  - HIGH: inactive edge → LOW; hold_high<=cnt (not yet visible).
  - LOW: active edge → HIGH; ic_period<=cnt, ic_high<=hold_high, ic_ccif<=1. If ic_ccif was already 1, ic_ocf<=1.
  - HIGH or LOW, counter at all-ones with a tick due: cnt saturates, ic_ovf<=1, → IDLE, no capture.
- ic_period and ic_high always update together. Output latency from synchronized edge to visible result is 1 clk.
- ic_busy = (state≠IDLE).
- ic_irq = CCIE&ic_ccif | OVIE&ic_ovf.
- Simultaneous events:
  - A flag set beats ccif_rst, ovf_rst or an SR clear in the same cycle.
  - A CR write beats an edge in the same cycle: the edge is ignored.
- Reset asserted mid-measurement aborts it with no capture.

Optional Feature:
- IC_FILTER_EN defined:
  - A digital filter sits between the synchronizer and the edge detector.
  - The filtered level changes only after FILT_LEN consecutive equal samples.
  - Glitches shorter than FILT_LEN clk are suppressed.
  - Both edges get equal delay, so measurements are unchanged for clean inputs.
- IC_FILTER_EN undefined: the synchronized level feeds the edge detector directly, and FILT_LEN is unused.

Decomposition:
- Package tim_ic_pkg holds:
  - register select constants IC_CR, IC_PSC, IC_SR, IC_NONE;
  - CR bit-index constants;
  - FSM state enum (IDLE, HIGH, LOW).
- Sub-module tim_ic_edge_in holds the synchronizer, the optional filter, the polarity XOR and the edge detector. Its outputs are act_edge and inact_edge pulses.

Test Plan:
- CR=0x5, PSC=0, pin high 3 clk / low 7 clk, repeated → after the 2nd rising edge: ic_period=10, ic_high=3, ic_ccif=1, ic_irq=1.
- PSC=3, pin high 20 clk / period 50 clk → ic_period=12, ic_high=5.
- POL=1, pin low 4 / high 6 → ic_high=4, ic_period=10. Two periods with no ccif_rst → ic_ocf=1.
- PSC=0, pin held high after one active edge for 65536+ clk → ic_ovf=1, ic_busy=0, ic_period unchanged. With OVIE=1 → ic_irq=1.
- With IC_FILTER_EN and FILT_LEN=4, a 2-clk low glitch inside a 10-clk high → no inactive edge, ic_high=10. Without the macro → ic_high=2.
- rst pulse during HIGH, and a CR write during LOW → FSM IDLE, no capture, flags as specified. A ccif_rst coinciding with a new capture → ic_ccif stays 1.

Source files
------------

// File: rtl/tim_ic_pkg.sv
// Shared constants for the input-capture timer channel: register selects,
// CR bit positions and the measurement FSM states.
package tim_ic_pkg;

    localparam logic [3:0] IC_CR   = 4'd0;
    localparam logic [3:0] IC_PSC  = 4'd1;
    localparam logic [3:0] IC_SR   = 4'd2;
    localparam logic [3:0] IC_NONE = 4'd15;

    localparam int CR_CEN  = 0;
    localparam int CR_POL  = 1;
    localparam int CR_CCIE = 2;
    localparam int CR_OVIE = 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } ic_state_e;

endpackage

// File: rtl/tim_ic_edge_in.sv
// Input conditioning for the capture pin: synchronizer, optional glitch
// filter (IC_FILTER_EN), polarity correction and active/inactive edge pulses.
module tim_ic_edge_in #(
    parameter int FILT_LEN = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pin,
    input  logic pol,
    output logic act_edge,
    output logic inact_edge
);

    if (FILT_LEN < 2 || FILT_LEN > 15) begin : g_bad_filt_len
        $error("tim_ic_edge_in: FILT_LEN must be in 2..15");
    end

    logic sync1;
    logic sync2;
    logic level;
    logic corr;
    logic prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= pin;
            sync2 <= sync1;
        end
    end

`ifdef IC_FILTER_EN
    logic [3:0] filt_cnt;
    logic       filt_lvl;

    // The level flips only once FILT_LEN samples in a row disagree with it,
    // so rising and falling edges are delayed by the same amount.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            filt_cnt <= 4'd0;
            filt_lvl <= 1'b0;
        end else if (sync2 == filt_lvl) begin
            filt_cnt <= 4'd0;
        end else if (filt_cnt == 4'(FILT_LEN - 1)) begin
            filt_lvl <= sync2;
            filt_cnt <= 4'd0;
        end else begin
            filt_cnt <= filt_cnt + 4'd1;
        end
    end

    assign level = filt_lvl;
`else
    assign level = sync2;
`endif

    assign corr = level ^ pol;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev <= 1'b0;
        end else begin
            prev <= corr;
        end
    end

    assign act_edge   = corr & ~prev;
    assign inact_edge = ~corr & prev;

endmodule

// File: rtl/tim_pwm_capture.sv
// Input-capture timer channel: measures period and active time of ic_pin in
// prescaled ticks. Optional input glitch filter enabled by IC_FILTER_EN.
module tim_pwm_capture
    import tim_ic_pkg::*;
#(
    parameter int FILT_LEN = 4,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       ld_ic_reg,
    input  logic [31:0]      data_reg,
    input  logic             ccif_rst,
    input  logic             ovf_rst,
    input  logic             ic_pin,
    output logic [CNT_W-1:0] ic_period,
    output logic [CNT_W-1:0] ic_high,
    output logic             ic_ccif,
    output logic             ic_ocf,
    output logic             ic_ovf,
    output logic             ic_irq,
    output logic             ic_busy
);

    logic             cen;
    logic             pol;
    logic             ccie;
    logic             ovie;
    logic [CNT_W-1:0] psc_reg;
    logic [CNT_W-1:0] psc_act;
    logic [CNT_W-1:0] psc_cnt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] hold_high;
    ic_state_e        state;

    logic act_edge;
    logic inact_edge;
    logic cr_wr;
    logic psc_wr;
    logic sr_wr;
    logic tick;
    logic ovf_evt;
    logic start;
    logic capture;
    logic sat;
    logic to_low;
    logic ccif_clr;
    logic ovf_clr;
    logic unused_data;

    tim_ic_edge_in #(
        .FILT_LEN (FILT_LEN)
    ) u_edge_in (
        .clk        (clk),
        .rst        (rst),
        .pin        (ic_pin),
        .pol        (pol),
        .act_edge   (act_edge),
        .inact_edge (inact_edge)
    );

    assign cr_wr    = (ld_ic_reg == IC_CR);
    assign psc_wr   = (ld_ic_reg == IC_PSC);
    assign sr_wr    = (ld_ic_reg == IC_SR);
    assign ccif_clr = ccif_rst | (sr_wr & data_reg[0]);
    assign ovf_clr  = ovf_rst | (sr_wr & data_reg[1]);
    assign tick     = (psc_cnt == psc_act);
    assign ovf_evt  = tick & (&cnt);
    assign unused_data = ^data_reg;

    // A CR write in the same cycle as an edge wins: the edge is dropped.
    always_comb begin
        start   = 1'b0;
        capture = 1'b0;
        sat     = 1'b0;
        to_low  = 1'b0;
        if (!cr_wr && cen) begin
            case (state)
                IDLE: start = act_edge;
                HIGH: begin
                    if (ovf_evt)         sat    = 1'b1;
                    else if (inact_edge) to_low = 1'b1;
                end
                LOW: begin
                    if (act_edge)     capture = 1'b1;
                    else if (ovf_evt) sat     = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cen     <= 1'b0;
            pol     <= 1'b0;
            ccie    <= 1'b0;
            ovie    <= 1'b0;
            psc_reg <= '0;
        end else begin
            if (cr_wr) begin
                cen  <= data_reg[CR_CEN];
                pol  <= data_reg[CR_POL];
                ccie <= data_reg[CR_CCIE];
                ovie <= data_reg[CR_OVIE];
            end
            if (psc_wr) begin
                psc_reg <= data_reg[CNT_W-1:0];
            end
        end
    end

    // Every active edge restarts the count so that a capture equals
    // floor(elapsed clocks / (PSC+1)); a new PSC is picked up only here.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            psc_cnt   <= '0;
            psc_act   <= '0;
            hold_high <= '0;
            ic_period <= '0;
            ic_high   <= '0;
        end else if (cr_wr) begin
            state   <= IDLE;
            cnt     <= '0;
            psc_cnt <= '0;
        end else if (!cen) begin
            state <= IDLE;
        end else if (start || capture) begin
            state   <= HIGH;
            psc_act <= psc_reg;
            if (psc_reg == '0) begin
                cnt     <= CNT_W'(1);
                psc_cnt <= '0;
            end else begin
                cnt     <= '0;
                psc_cnt <= CNT_W'(1);
            end
            if (capture) begin
                ic_period <= cnt;
                ic_high   <= hold_high;
            end
        end else if (sat) begin
            state <= IDLE;
        end else if (state != IDLE) begin
            if (tick) begin
                psc_cnt <= '0;
                cnt     <= cnt + CNT_W'(1);
            end else begin
                psc_cnt <= psc_cnt + CNT_W'(1);
            end
            if (to_low) begin
                state     <= LOW;
                hold_high <= cnt;
            end
        end
    end

    // Setting a flag always beats clearing it in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ic_ccif <= 1'b0;
            ic_ocf  <= 1'b0;
            ic_ovf  <= 1'b0;
        end else begin
            if (capture)       ic_ccif <= 1'b1;
            else if (ccif_clr) ic_ccif <= 1'b0;

            if (capture && ic_ccif) ic_ocf <= 1'b1;
            else if (ccif_clr)      ic_ocf <= 1'b0;

            if (sat)          ic_ovf <= 1'b1;
            else if (ovf_clr) ic_ovf <= 1'b0;
        end
    end

    assign ic_busy = (state != IDLE);
    assign ic_irq  = (ccie & ic_ccif) | (ovie & ic_ovf);

endmodule
